// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-fetch responder.
package imem_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } imem_rsp_t;

  // Word-aligned and inside a RAM of 'depth' words.
  function automatic logic imem_addr_ok(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && (32'(addr[31:2]) < depth);
  endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Shift-style response FIFO: entry 0 is always the head, so the head is a plain register.
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clr,
  input  logic      push,
  input  imem_rsp_t push_data,
  input  logic      pop,
  output logic      valid,
  output imem_rsp_t head
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  imem_rsp_t       slot_q [DEPTH];
  imem_rsp_t       slot_d [DEPTH];
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;

  // Pop shifts entries toward the head; push lands behind the surviving entries.
  always_comb begin
    slot_d  = slot_q;
    count_d = count_q;
    if (pop && (count_q != '0)) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
        slot_d[i] = slot_q[i+1];
      end
      count_d = count_q - CW'(1);
    end
    if (push) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CW'(i) == count_d) begin
          slot_d[i] = push_data;
        end
      end
      count_d = count_d + CW'(1);
    end
  end

  // Storage and occupancy; reset and clear both empty the queue and zero the head.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      slot_q  <= slot_d;
    end
  end

  assign valid = (count_q != '0);
  assign head  = slot_q[0];

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: local RAM, fixed-latency read pipeline, credit-limited response FIFO.
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS     = 1024,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_addr,
  output logic        rsp_err,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        busy
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam int unsigned CW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned NSTG = LATENCY - 1;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [CW-1:0] cnt;
  logic          accept;
  logic          consume;
  logic          req_err;
  imem_rsp_t     rd_rsp;
  imem_rsp_t     wr_rsp;
  logic          wr_en;
  imem_rsp_t     head;
  logic          fifo_valid;

  assign consume   = fifo_valid && rsp_ready;
  assign req_ready = !rst && !load_en && !flush &&
                     ((cnt < CW'(MAX_OUTSTANDING)) || consume);
  assign accept    = req_valid && req_ready;
  assign req_err   = !imem_addr_ok(req_addr, DEPTH_WORDS);

  // Read captured at the accept edge; errored requests answer with a NOP instead of RAM data.
  always_comb begin
    rd_rsp       = '0;
    rd_rsp.addr  = req_addr;
    rd_rsp.err   = req_err;
    rd_rsp.instr = req_err ? INSTR_NOP : mem[req_addr[AW+1:2]];
  end

  // Boot-load write port; bad addresses are dropped so they cannot alias onto valid words.
  always_ff @(posedge clk) begin
    if (load_en && imem_addr_ok(load_addr, DEPTH_WORDS)) begin
      mem[load_addr[AW+1:2]] <= load_data;
    end
  end

  // The accept edge is the first stage; the FIFO write is the last, so LATENCY-1 registers sit between.
  if (LATENCY == 1) begin : g_direct
    assign wr_en  = accept;
    assign wr_rsp = rd_rsp;
  end else begin : g_pipe
    logic      pv [NSTG];
    imem_rsp_t pd [NSTG];

    // Stage valids, cleared by reset or flush.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        for (int unsigned i = 0; i < NSTG; i++) begin
          pv[i] <= 1'b0;
        end
      end else begin
        pv[0] <= accept;
        for (int unsigned i = 1; i < NSTG; i++) begin
          pv[i] <= pv[i-1];
        end
      end
    end

    // Stage payloads advance every cycle; only qualified by the valids.
    always_ff @(posedge clk) begin
      pd[0] <= rd_rsp;
      for (int unsigned i = 1; i < NSTG; i++) begin
        pd[i] <= pd[i-1];
      end
    end

    assign wr_en  = pv[NSTG-1];
    assign wr_rsp = pd[NSTG-1];
  end

  // Credit counter: accepted but not yet consumed.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt <= '0;
    end else if (accept && !consume) begin
      cnt <= cnt + CW'(1);
    end else if (!accept && consume) begin
      cnt <= cnt - CW'(1);
    end
  end

  imem_rsp_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .push      (wr_en),
    .push_data (wr_rsp),
    .pop       (consume),
    .valid     (fifo_valid),
    .head      (head)
  );

  assign rsp_valid = fifo_valid;
  assign rsp_instr = head.instr;
  assign rsp_addr  = head.addr;
  assign rsp_err   = head.err;
  assign busy      = (cnt != '0);

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder (DEPTH_WORDS=1024, LATENCY=2, MAX_OUTSTANDING=2).
module tb_imem_fetch_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_err;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // {rsp_valid, rsp_err, rsp_addr, rsp_instr}
  logic [65:0] got;
  logic [65:0] exp;

  localparam logic [31:0] NOP = 32'h00000013;

  imem_fetch_responder #(
    .DEPTH_WORDS     (1024),
    .LATENCY         (2),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are then set for the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    got = {rsp_valid, rsp_err, rsp_addr, rsp_instr};
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    rsp_ready = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    step();
    req_valid = 1'b1;
    mid();
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b exp 0", req_ready); end
    step();
    rst = 1'b0; req_valid = 1'b0;
    mid();
    exp = {1'b0, 1'b0, 32'h0, 32'h0};
    checks++;
    if (got !== exp || busy !== 1'b0) begin errors++; $display("FAIL rst_outputs got %h busy %b exp %h busy 0", got, busy, exp); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_load_fetch();
    logic [31:0] la [7];
    logic [31:0] ld [7];
    la = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h20, 32'hFFC};
    ld = '{32'h00500093, 32'h00a00113, 32'h11111111, 32'h22222222,
           32'h44444444, 32'h33333333, 32'h55555555};
    for (int i = 0; i < 7; i++) begin
      step();
      load_en = 1'b1; load_addr = la[i]; load_data = ld[i];
    end
    step();
    load_en = 1'b0; req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b1;
    mid();
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL lf_ready got %b exp 1", req_ready); end
    step();
    req_addr = 32'h4;
    mid();
    exp = {1'b0, 1'b0, 32'h0, 32'h0};
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL lf_early got %b exp 0", rsp_valid); end
    step();
    req_valid = 1'b0;
    mid();
    exp = {1'b1, 1'b0, 32'h0, 32'h00500093};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL lf_rsp0 got %h exp %h", got, exp); end
    step();
    mid();
    exp = {1'b1, 1'b0, 32'h4, 32'h00a00113};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL lf_rsp1 got %h exp %h", got, exp); end
    step();
    mid();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL lf_idle got valid %b busy %b exp 0 0", rsp_valid, busy); end
  endtask

  task automatic test_backpressure();
    step();
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
    mid();
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0 got %b exp 1", req_ready); end
    step();
    req_addr = 32'h4;
    mid();
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b exp 1", req_ready); end
    step();
    req_addr = 32'h8;
    mid();
    exp = {1'b1, 1'b0, 32'h0, 32'h00500093};
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_full got %b exp 0", req_ready); end
    checks++;
    if (got !== exp) begin errors++; $display("FAIL bp_head got %h exp %h", got, exp); end
    step();
    mid();
    checks++;
    if (got !== exp || req_ready !== 1'b0) begin errors++; $display("FAIL bp_stable got %h ready %b exp %h ready 0", got, req_ready, exp); end
    step();
    rsp_ready = 1'b1;
    mid();
    checks++;
    if (req_ready !== 1'b1 || got !== exp) begin errors++; $display("FAIL bp_release got %h ready %b exp %h ready 1", got, req_ready, exp); end
    step();
    req_valid = 1'b0;
    mid();
    exp = {1'b1, 1'b0, 32'h4, 32'h00a00113};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL bp_rsp1 got %h exp %h", got, exp); end
    step();
    mid();
    exp = {1'b1, 1'b0, 32'h8, 32'h11111111};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL bp_rsp2 got %h exp %h", got, exp); end
    step();
    mid();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_idle got valid %b busy %b exp 0 0", rsp_valid, busy); end
  endtask

  task automatic test_errors();
    step();
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h2;
    step();
    req_addr = 32'h1000;
    step();
    req_addr = 32'hFFC;
    mid();
    exp = {1'b1, 1'b1, 32'h2, NOP};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL err_misaligned got %h exp %h", got, exp); end
    step();
    req_valid = 1'b0;
    mid();
    exp = {1'b1, 1'b1, 32'h1000, NOP};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL err_range got %h exp %h", got, exp); end
    step();
    mid();
    exp = {1'b1, 1'b0, 32'hFFC, 32'h55555555};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL err_last_word got %h exp %h", got, exp); end
    step();
    mid();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL err_idle got busy %b exp 0", busy); end
  endtask

  task automatic test_flush();
    step();
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h8;
    step();
    req_addr = 32'hC;
    step();
    req_addr = 32'h24; rsp_ready = 1'b0; flush = 1'b1;
    mid();
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL fl_ready got %b exp 0", req_ready); end
    step();
    flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    mid();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fl_after got valid %b busy %b exp 0 0", rsp_valid, busy); end
    step();
    req_valid = 1'b1; req_addr = 32'h20;
    mid();
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL fl_stale got %b exp 0", rsp_valid); end
    step();
    req_valid = 1'b0;
    mid();
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL fl_stale2 got %b exp 0", rsp_valid); end
    step();
    mid();
    exp = {1'b1, 1'b0, 32'h20, 32'h33333333};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL fl_new got %h exp %h", got, exp); end
    step();
    mid();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fl_idle got valid %b busy %b exp 0 0", rsp_valid, busy); end
  endtask

  task automatic test_load_vs_fetch();
    step();
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h10;
    step();
    load_en = 1'b1; load_addr = 32'h10; load_data = 32'hDEADBEEF;
    mid();
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL lv_blocked got %b exp 0", req_ready); end
    step();
    load_en = 1'b0;
    mid();
    exp = {1'b1, 1'b0, 32'h10, 32'h44444444};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL lv_old got %h exp %h", got, exp); end
    step();
    req_valid = 1'b0;
    mid();
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL lv_gap got %b exp 0", rsp_valid); end
    step();
    load_en = 1'b1; load_addr = 32'h1020; load_data = 32'h00000BAD;
    mid();
    exp = {1'b1, 1'b0, 32'h10, 32'hDEADBEEF};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL lv_new got %h exp %h", got, exp); end
    step();
    load_addr = 32'h21;
    step();
    load_en = 1'b0; req_valid = 1'b1; req_addr = 32'h20;
    step();
    req_valid = 1'b0;
    step();
    mid();
    exp = {1'b1, 1'b0, 32'h20, 32'h33333333};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL lv_bad_write got %h exp %h", got, exp); end
    step();
  endtask

  task automatic test_reset_mid();
    step();
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
    step();
    req_addr = 32'h4;
    step();
    req_valid = 1'b0; rst = 1'b1;
    mid();
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rm_assert got ready %b busy %b exp 0 1", req_ready, busy); end
    step();
    mid();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL rm_cleared got valid %b busy %b ready %b exp 0 0 0", rsp_valid, busy, req_ready);
    end
    step();
    rst = 1'b0; rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
    mid();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_release got ready %b valid %b exp 1 0", req_ready, rsp_valid); end
    step();
    req_valid = 1'b0;
    mid();
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_stale got %b exp 0", rsp_valid); end
    step();
    mid();
    exp = {1'b1, 1'b0, 32'h0, 32'h00500093};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL rm_fetch got %h exp %h", got, exp); end
    step();
    mid();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_idle got valid %b busy %b exp 0 0", rsp_valid, busy); end
  endtask

  initial begin
    test_reset();
    test_load_fetch();
    test_backpressure();
    test_errors();
    test_flush();
    test_load_vs_fetch();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
- Responder side of the instruction-fetch interface. Serves word fetch requests from a core's IF stage out of a local instruction RAM.
- Response latency is configurable. At most MAX_OUTSTANDING requests can be in flight at once.
- Responses are buffered with credit-based flow control.
- A flush input discards in-flight responses on a branch redirect.
- A load port lets the boot loader or testbench write the RAM.
- One instance per core sits between that core's fetch stage and its program memory.

Parameters:
- DEPTH_WORDS, 1024: RAM size in 32-bit words. Power of two.
- LATENCY, 2: cycles from request acceptance to earliest rsp_valid. Legal range 1..4.
- MAX_OUTSTANDING, 2: maximum accepted-but-not-consumed requests. Legal range 1..4. Also sets the response FIFO depth.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- req_valid  input  1  fetch request present
- req_ready  output  1  responder can accept a request this cycle
- req_addr  input  32  byte address of the fetch
- flush  input  1  discard all in-flight and buffered responses
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer takes the response
- rsp_instr  output  32  fetched instruction word
- rsp_addr  output  32  byte address of the request this response answers
- rsp_err  output  1  request was misaligned or out of range
- load_en  input  1  RAM write strobe
- load_addr  input  32  byte address for the write
- load_data  input  32  word to write
- busy  output  1  in-flight or buffered responses exist

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_err=0, busy=0. Outstanding count = 0, pipeline valids = 0, FIFO empty. req_ready=0 while rst=1. RAM contents are not reset.
- Outstanding count (cnt): incremented on accept, decremented on response consumption (rsp_valid && rsp_ready). Both in the same cycle leaves cnt unchanged.
- req_ready = !rst && !load_en && !flush && (cnt < MAX_OUTSTANDING || (rsp_valid && rsp_ready)).
- Accept condition: req_valid && req_ready.
- RAM read timing: the RAM is read synchronously at the accept edge, so data reflects RAM state at that edge.
- Error check: error = (req_addr[1:0] != 0) || (req_addr[31:2] >= DEPTH_WORDS).
  - On error the RAM is not read.
  - The response carries rsp_instr = 32'h00000013 (NOP) and rsp_err = 1.
- Read pipeline: LATENCY-stage shift register of {valid, addr, instr, err}, advancing every cycle with no stall.
- Pipeline exit: the final stage writes into the response FIFO. The FIFO cannot overflow because of the credit rule.
- Response output: rsp_* are driven from the FIFO head (registered). A request accepted at the edge ending cycle T shows rsp_valid=1 at the earliest in cycle T+LATENCY.
- Ordering: responses are returned strictly in accept order.
- Back-to-back requests: with rsp_ready held at 1 and MAX_OUTSTANDING >= LATENCY, sustained throughput is one response per cycle.
- rsp_ready=0: rsp_* stay stable until consumed, and further requests are refused once cnt reaches MAX_OUTSTANDING.
- flush=1: at that edge all pipeline valids are cleared, the FIFO is emptied, and cnt is set to 0.
  - No request is accepted in the flush cycle.
  - A response visible in the flush cycle counts as consumed only if rsp_ready=1. Either way it is gone next cycle.
- load_en=1: writes mem[load_addr[31:2]] = load_data at the edge.
  - The write is ignored if load_addr is misaligned or out of range.
  - Requests are blocked during load_en. In-flight reads keep the data captured before the write.
- busy = (cnt != 0).
- Reset mid-operation: everything returns to reset values at the next edge. In-flight requests are lost without any response.

Decomposition:
- Package imem_pkg holds:
  - INSTR_NOP = 32'h00000013
  - typedef imem_rsp_t {logic [31:0] instr; logic [31:0] addr; logic err;}
  - function imem_addr_ok(addr, depth)
- Sub-module imem_rsp_fifo: parameterised synchronous FIFO of imem_rsp_t with a flush (clear) input and depth MAX_OUTSTANDING.
- RAM storage, read pipeline, and credit counter live in the top module.

Test Plan:
- Load then fetch: load 0x0000_0000 <- 0x00500093 and 0x4 <- 0x00a00113. Then fetch 0x0 and 0x4 on consecutive cycles with rsp_ready=1 -> responses in cycles T+2 and T+3 with instr 0x00500093 then 0x00a00113, addr 0x0 then 0x4, err=0.
- Backpressure (MAX_OUTSTANDING=2): hold rsp_ready=0 and issue 3 requests -> req_ready drops after 2 accepts, rsp_valid=1 with addr 0x0 stable. Raise rsp_ready -> third request accepted in the same cycle the first response is consumed.
- Errors: fetch 0x2 -> rsp_err=1, rsp_instr=0x00000013. Fetch 0x1000 (DEPTH_WORDS=1024) -> rsp_err=1, rsp_instr=0x00000013.
- Flush: accept 0x8 and 0xC, assert flush one cycle later -> no rsp_valid for either, busy=0 next cycle. A fetch of 0x20 issued after that returns only 0x20.
- Load vs fetch: assert load_en with req_valid=1 -> req_ready=0, and the write of 0xDEADBEEF to 0x10 lands. A prior in-flight fetch of 0x10 returns the old word; a subsequent fetch returns 0xDEADBEEF.
- Mid-operation reset: assert rst with 2 requests outstanding -> next cycle rsp_valid=0, busy=0, req_ready=0. After release, a fetch of 0x0 returns the RAM contents with no stale responses.
